// File: rtl/despejo_registradores.sv
// despejo_registradores: sweeps a register-file index range and streams (index, data) beats.
// Optional trailing XOR checksum beat when DESPEJO_CHECKSUM_EN is defined.
module despejo_registradores #(
  parameter int PRIMEIRO_REG = 0,
  parameter int ULTIMO_REG   = 31
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Iniciar,
  output logic [4:0]  Reg_leitura,
  input  logic [31:0] Reg_dados_lidos,
  output logic [31:0] Saida_dados,
  output logic [4:0]  Saida_indice,
  output logic        Saida_checksum,
  output logic        Saida_valida,
  input  logic        Saida_pronta,
  output logic        Ocupado,
  output logic        Concluido
);

  localparam logic [4:0] PRIMEIRO = 5'(PRIMEIRO_REG);
  localparam logic [4:0] ULTIMO   = 5'(ULTIMO_REG);

`ifdef DESPEJO_CHECKSUM_EN
  typedef enum logic [2:0] {
    OCIOSO, LER, ENVIAR, SOMA, FIM
  } estado_t;
  logic [31:0] acumulador;
`else
  typedef enum logic [1:0] {
    OCIOSO, LER, ENVIAR, FIM
  } estado_t;
`endif

  estado_t estado, estado_prox;
  logic [4:0] indice;
  logic transf;
  logic eh_ultimo;

  assign transf      = Saida_valida && Saida_pronta;
  assign eh_ultimo   = (indice == ULTIMO);
  assign Reg_leitura = indice;
  assign Ocupado     = (estado != OCIOSO);
  assign Concluido   = (estado == FIM);

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) estado <= OCIOSO;
    else       estado <= estado_prox;
  end

  // Next-state decode
  always_comb begin
    estado_prox = estado;
    unique case (estado)
      OCIOSO: if (Iniciar) estado_prox = LER;
      LER:    estado_prox = ENVIAR;
      ENVIAR: begin
        if (transf) begin
          if (!eh_ultimo) estado_prox = LER;
`ifdef DESPEJO_CHECKSUM_EN
          else            estado_prox = SOMA;
`else
          else            estado_prox = FIM;
`endif
        end
      end
`ifdef DESPEJO_CHECKSUM_EN
      SOMA:   if (transf) estado_prox = FIM;
`endif
      FIM:    estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

`ifndef DESPEJO_CHECKSUM_EN
  assign Saida_checksum = 1'b0;
`endif

  // Index counter, beat capture and handshake
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      indice       <= PRIMEIRO;
      Saida_dados  <= '0;
      Saida_indice <= '0;
      Saida_valida <= 1'b0;
`ifdef DESPEJO_CHECKSUM_EN
      Saida_checksum <= 1'b0;
      acumulador     <= '0;
`endif
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (Iniciar) begin
            indice <= PRIMEIRO;
`ifdef DESPEJO_CHECKSUM_EN
            acumulador <= '0;
`endif
          end
        end
        LER: begin
          Saida_dados  <= Reg_dados_lidos;
          Saida_indice <= indice;
          Saida_valida <= 1'b1;
`ifdef DESPEJO_CHECKSUM_EN
          Saida_checksum <= 1'b0;
          acumulador     <= acumulador ^ Reg_dados_lidos;
`endif
        end
        ENVIAR: begin
          if (transf) begin
            Saida_valida <= 1'b0;
            if (!eh_ultimo) indice <= indice + 5'd1;
          end
        end
`ifdef DESPEJO_CHECKSUM_EN
        SOMA: begin
          if (!Saida_valida) begin
            Saida_dados    <= acumulador;
            Saida_indice   <= '0;
            Saida_checksum <= 1'b1;
            Saida_valida   <= 1'b1;
          end else if (Saida_pronta) begin
            Saida_valida   <= 1'b0;
            Saida_checksum <= 1'b0;
          end
        end
`endif
        FIM: indice <= PRIMEIRO;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_despejo_registradores.sv
// Bench for despejo_registradores: transaction-level model of the dump,
// per-cycle output comparison, directed pins and randomized runs.
module tb_despejo_registradores;

  typedef struct {
    logic [4:0]  i;
    logic [31:0] d;
    logic        c;
  } beat_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Iniciar = 1'b0;
  logic [4:0]  Reg_leitura;
  logic [31:0] Reg_dados_lidos;
  logic [31:0] Saida_dados;
  logic [4:0]  Saida_indice;
  logic        Saida_checksum;
  logic        Saida_valida;
  logic        Saida_pronta = 1'b1;
  logic        Ocupado;
  logic        Concluido;

  logic        Iniciar2 = 1'b0;
  logic [4:0]  Reg_leitura2;
  logic [31:0] Reg_dados_lidos2;
  logic [31:0] Saida_dados2;
  logic [4:0]  Saida_indice2;
  logic        Saida_checksum2;
  logic        Saida_valida2;
  logic        Ocupado2;
  logic        Concluido2;

  logic [31:0] regs [32];

  always_comb Reg_dados_lidos  = regs[Reg_leitura];
  always_comb Reg_dados_lidos2 = regs[Reg_leitura2];

  despejo_registradores dut (
    .Clock(Clock), .Reset(Reset), .Iniciar(Iniciar),
    .Reg_leitura(Reg_leitura), .Reg_dados_lidos(Reg_dados_lidos),
    .Saida_dados(Saida_dados), .Saida_indice(Saida_indice),
    .Saida_checksum(Saida_checksum), .Saida_valida(Saida_valida),
    .Saida_pronta(Saida_pronta), .Ocupado(Ocupado),
    .Concluido(Concluido)
  );

  despejo_registradores #(.PRIMEIRO_REG(5), .ULTIMO_REG(5)) dut2 (
    .Clock(Clock), .Reset(Reset), .Iniciar(Iniciar2),
    .Reg_leitura(Reg_leitura2), .Reg_dados_lidos(Reg_dados_lidos2),
    .Saida_dados(Saida_dados2), .Saida_indice(Saida_indice2),
    .Saida_checksum(Saida_checksum2), .Saida_valida(Saida_valida2),
    .Saida_pronta(1'b1), .Ocupado(Ocupado2),
    .Concluido(Concluido2)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [63:0] a,
                     input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nome, a, e, cyc);
    end
  endtask

  // Ready patterns: 0 always ready, 1 toggling, 2 random
  int modo = 0;
  always @(posedge Clock) begin
    #1;
    case (modo)
      1:       Saida_pronta = ~Saida_pronta;
      2:       Saida_pronta = ($urandom_range(0, 3) != 0);
      default: Saida_pronta = 1'b1;
    endcase
  end

  // Behavioural model: list of beats still owed, plus phase flags
  beat_t q[$];
  bit busy_m = 0, pend_m = 0, vld_m = 0, conc_m = 0;
  int beats_m = 0, start_cyc = 0, done_cyc = 0, dumps_done = 0;
  logic [4:0]  got_i [40];
  logic [31:0] got_d [40];
  logic [31:0] cks_got = '0;
  bit prev_v = 0, prev_r = 0;
  logic [36:0] prev_p = '0;

  task automatic build_queue();
    logic [31:0] x;
    x = '0;
    q.delete();
    for (int i = 0; i < 32; i++) begin
      q.push_back('{i[4:0], regs[i], 1'b0});
      x = x ^ regs[i];
    end
`ifdef DESPEJO_CHECKSUM_EN
    q.push_back('{5'd0, x, 1'b1});
`endif
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      q.delete();
      busy_m = 0; pend_m = 0; vld_m = 0; conc_m = 0;
      prev_v = 0;
    end else begin
      bit n_busy, n_pend, n_vld, n_conc;
      chk("ocupado", {63'd0, Ocupado}, {63'd0, busy_m});
      chk("concluido", {63'd0, Concluido}, {63'd0, conc_m});
      chk("valida", {63'd0, Saida_valida}, {63'd0, vld_m});
      if (vld_m && q.size() > 0) begin
        chk("indice", {59'd0, Saida_indice}, {59'd0, q[0].i});
        chk("dados", {32'd0, Saida_dados}, {32'd0, q[0].d});
        chk("checksum", {63'd0, Saida_checksum}, {63'd0, q[0].c});
      end
      if (!busy_m)
        chk("leitura_ocioso", {59'd0, Reg_leitura}, 64'd0);
      if (pend_m && q.size() > 0 && !q[0].c)
        chk("leitura_ler", {59'd0, Reg_leitura}, {59'd0, q[0].i});
      if (prev_v && !prev_r && Saida_valida)
        chk("estavel", {27'd0, Saida_indice, Saida_dados},
            {27'd0, prev_p});
      prev_v = Saida_valida;
      prev_r = Saida_pronta;
      prev_p = {Saida_indice, Saida_dados};

      n_busy = busy_m; n_pend = pend_m;
      n_vld = vld_m; n_conc = conc_m;
      if (conc_m) begin
        n_conc = 0; n_busy = 0;
        done_cyc = cyc; dumps_done++;
      end
      if (pend_m) begin
        n_pend = 0; n_vld = 1;
      end
      if (vld_m && Saida_pronta && q.size() > 0) begin
        if (q[0].c) cks_got = Saida_dados;
        else if (beats_m < 40) begin
          got_i[beats_m] = Saida_indice;
          got_d[beats_m] = Saida_dados;
        end
        void'(q.pop_front());
        beats_m++;
        n_vld = 0;
        if (q.size() == 0) n_conc = 1;
        else               n_pend = 1;
      end
      if (!busy_m && Iniciar) begin
        build_queue();
        n_busy = 1; n_pend = 1;
        start_cyc = cyc + 1;
        beats_m = 0;
      end
      busy_m = n_busy; pend_m = n_pend;
      vld_m = n_vld; conc_m = n_conc;
    end
  end

  task automatic start_dump();
    @(posedge Clock); #1 Iniciar = 1'b1;
    @(posedge Clock); #1 Iniciar = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(posedge Clock);
      if (!busy_m) break;
    end
    chk("idle_wait", {63'd0, busy_m}, 64'd0);
  endtask

  task automatic wait_beats(input int n);
    for (int k = 0; k < 400; k++) begin
      @(posedge Clock);
      if (beats_m >= n) break;
    end
    chk("beat_wait", {63'd0, beats_m >= n}, 64'd1);
  endtask

`ifdef DESPEJO_CHECKSUM_EN
  localparam int NBEATS = 33;
  localparam int DUR = 66;
`else
  localparam int NBEATS = 32;
  localparam int DUR = 64;
`endif

  initial begin
    int n2, dd;
    bit seen2;
    logic [4:0] i2;
    logic [31:0] d2;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_valida", {63'd0, Saida_valida}, 64'd0);
    chk("rst_ocupado", {63'd0, Ocupado}, 64'd0);
    chk("rst_concluido", {63'd0, Concluido}, 64'd0);
    chk("rst_dados", {32'd0, Saida_dados}, 64'd0);
    chk("rst_indice", {59'd0, Saida_indice}, 64'd0);
    chk("rst_checksum", {63'd0, Saida_checksum}, 64'd0);
    chk("rst_leitura", {59'd0, Reg_leitura}, 64'd0);
    chk("rst_leitura2", {59'd0, Reg_leitura2}, 64'd5);
    Reset = 1'b0;

    // Full sweep, sink always ready
    start_dump();
    wait_idle(200);
    chk("t1_beats", 64'(beats_m), 64'(NBEATS));
    chk("t1_d0", {32'd0, got_d[0]}, 64'h1000);
    chk("t1_d31", {32'd0, got_d[31]}, 64'h101F);
    chk("t1_i31", {59'd0, got_i[31]}, 64'd31);
    chk("t1_dur", 64'(done_cyc - start_cyc), 64'(DUR));

    // Single-register range instance
    @(posedge Clock); #1 Iniciar2 = 1'b1;
    @(posedge Clock); #1 Iniciar2 = 1'b0;
    n2 = 0; seen2 = 0; i2 = '0; d2 = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (Saida_valida2 && n2 == 0) begin
        i2 = Saida_indice2; d2 = Saida_dados2;
      end
      if (Saida_valida2) n2++;
      if (Concluido2) begin
        seen2 = 1;
        break;
      end
    end
    chk("t2_concluido", {63'd0, seen2}, 64'd1);
`ifdef DESPEJO_CHECKSUM_EN
    chk("t2_beats", 64'(n2), 64'd2);
`else
    chk("t2_beats", 64'(n2), 64'd1);
`endif
    chk("t2_indice", {59'd0, i2}, 64'd5);
    chk("t2_dados", {32'd0, d2}, 64'h1005);
    @(negedge Clock);
    chk("t2_ocioso", {63'd0, Ocupado2}, 64'd0);

    // Toggling ready
    modo = 1;
    start_dump();
    wait_idle(400);
    chk("t3_beats", 64'(beats_m), 64'(NBEATS));
    chk("t3_d17", {32'd0, got_d[17]}, 64'h1011);
    modo = 0;

    // Ignored restart at beat 10, reset at beat 20
    start_dump();
    wait_beats(10);
    #1 Iniciar = 1'b1;
    @(posedge Clock); #1 Iniciar = 1'b0;
    wait_beats(20);
    dd = dumps_done;
    #1 Reset = 1'b1;
    #1;
    chk("t4_rst_valida", {63'd0, Saida_valida}, 64'd0);
    chk("t4_rst_ocupado", {63'd0, Ocupado}, 64'd0);
    @(posedge Clock); #1 Reset = 1'b0;
    repeat (3) @(posedge Clock);
    chk("t4_no_conc", 64'(dumps_done), 64'(dd));
    start_dump();
    wait_idle(200);
    chk("t4_i0", {59'd0, got_i[0]}, 64'd0);
    chk("t4_beats", 64'(beats_m), 64'(NBEATS));

    // Randomized contents, ready and stray start pulses
    modo = 2;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      start_dump();
      for (int k = 0; k < 150; k++) begin
        @(posedge Clock);
        #1 Iniciar = ($urandom_range(0, 15) == 0);
      end
      Iniciar = 1'b0;
      wait_idle(600);
    end
    modo = 0;

`ifdef DESPEJO_CHECKSUM_EN
    for (int i = 0; i < 32; i++) regs[i] = i;
    start_dump(); wait_idle(200);
    chk("cks_seq", {32'd0, cks_got}, 64'h0);
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    start_dump(); wait_idle(200);
    chk("cks_1000", {32'd0, cks_got}, 64'h0);
    regs[31] = 32'hFFFFFFFF;
    start_dump(); wait_idle(200);
    chk("cks_ff", {32'd0, cks_got}, 64'hFFFFEFE0);
`endif

    repeat (3) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/despejo_registradores.md
# despejo_registradores

Register-dump reader for the 32×32-bit register file: on a start pulse it sweeps a configurable index range through the file's combinational read port, captures each word, and streams `(index, data)` beats out over a valid/ready handshake. It sits beside the register file, sharing one read port with the datapath, and feeds a debug/trace sink such as a UART or testbench monitor. It is the read-side counterpart to the file's write port: the datapath writes registers, and this block reads them all back out.

## Interface
- `PRIMEIRO_REG`, default 0: first register index dumped. Must satisfy `PRIMEIRO_REG <= ULTIMO_REG`.
- `ULTIMO_REG`, default 31: last register index dumped, inclusive.

- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `Iniciar`  in  1  start request; sampled only in `OCIOSO`.
- `Reg_leitura`  out  5  read address driven to the register file read port.
- `Reg_dados_lidos`  in  32  combinational read data returned for `Reg_leitura`.
- `Saida_dados`  out  32  captured register word for the current beat.
- `Saida_indice`  out  5  register index of the current beat.
- `Saida_checksum`  out  1  high when the beat carries the checksum word; tied 0 without the macro.
- `Saida_valida`  out  1  beat valid.
- `Saida_pronta`  in  1  sink ready.
- `Ocupado`  out  1  high in any state other than `OCIOSO`.
- `Concluido`  out  1  one-cycle pulse after the final beat transfers.

## Operation
- FSM states:
  - `OCIOSO`
  - `LER`: drive the address and capture on the next edge.
  - `ENVIAR`: hold the beat until accepted.
  - `SOMA`: checksum beat; exists only with the macro.
  - `FIM`: one cycle, asserts `Concluido`.
- Transitions:
  - `OCIOSO` → `LER` when `Iniciar`=1. The index counter loads `PRIMEIRO_REG` and the checksum accumulator clears.
  - `LER` → `ENVIAR`: capture `Reg_dados_lidos` into `Saida_dados` and the counter into `Saida_indice`, then set `Saida_valida`.
  - `ENVIAR`, transfer (`Saida_valida && Saida_pronta` at the edge):
    - If the index is not `ULTIMO_REG`: increment the index, go to `LER`.
    - If the index is `ULTIMO_REG`: go to `SOMA` (macro) or `FIM`.
    - `Saida_valida` deasserts on the transfer edge.
  - `SOMA` → `FIM` on transfer. `FIM` → `OCIOSO` unconditionally.
- `Reg_leitura` equals the index counter in every state. It holds `PRIMEIRO_REG` while idle.
- Beat payload is stable while `Saida_valida`=1 and not yet accepted. `Saida_valida` never drops without a transfer, except on `Reset`.
- `Iniciar` is ignored while `Ocupado`=1; there is no queuing. `Iniciar` in the same cycle as the `FIM`→`OCIOSO` transition is also ignored.
- Each word is a snapshot taken at its `LER` edge. Register-file writes that land mid-dump are seen only by registers not yet captured. No coherency across the sweep.
- Index arithmetic is 5-bit. `ULTIMO_REG`=31 terminates by comparison, never by wrap.
- Reset values: `Saida_dados`=0, `Saida_indice`=0, `Saida_checksum`=0, `Saida_valida`=0, `Ocupado`=0, `Concluido`=0, `Reg_leitura`=`PRIMEIRO_REG`, state `OCIOSO`.
- `Reset` asserted mid-dump aborts at once. No `Concluido` is produced and an in-flight beat is dropped.

## Timing
- `Iniciar` sampled at edge t → `LER` during t..t+1 with `Reg_leitura`=`PRIMEIRO_REG` → `Saida_valida`=1 after edge t+1.
- Per-beat cost is 2 cycles with `Saida_pronta` held high. A full 32-register dump takes 64 cycles from the start edge to the last transfer.
- `Concluido` is high for exactly the cycle after the last transfer. `Ocupado` falls one edge later.
- Back-pressure: each cycle with `Saida_pronta`=0 while valid adds one cycle. There is no combinational path from `Saida_pronta` to any output.

## Configuration
- `DESPEJO_CHECKSUM_EN` defined:
  - The accumulator XORs every captured word.
  - After the last register beat, one extra beat carries `Saida_dados`=XOR of all dumped words, `Saida_indice`=0 and `Saida_checksum`=1.
  - The sweep costs 2 extra cycles, counted from the last register transfer.
- Undefined: no accumulator and no `SOMA` state, and `Saida_checksum` is tied 0.

## Test plan
- Preload r[i]=0x1000+i, default params, `Saida_pronta`=1, pulse `Iniciar` → 32 beats, indices 0..31 with data 0x1000..0x101F, `Concluido` pulse after the 64th cycle.
- `PRIMEIRO_REG`=5, `ULTIMO_REG`=5 → exactly one beat (5, 0x1005), then `Concluido`, then idle.
- Toggle `Saida_pronta` 0/1 each cycle → same 32 beats with no loss or duplication, and the payload holds stable across stalls.
- Pulse `Iniciar` again at beat 10 → ignored, with no restart and sequence intact. Assert `Reset` at beat 20 → `Saida_valida`/`Ocupado` drop immediately, no `Concluido`, and a new `Iniciar` restarts at index 0.
- With `DESPEJO_CHECKSUM_EN`, r[i]=i → 33rd beat has `Saida_checksum`=1 and `Saida_dados`=0x00000000 (XOR of 0..31). With r[i]=0x1000+i → checksum 0x00000000. With r[31]=0xFFFFFFFF → checksum 0xFFFFEFE0.
